// File: rtl/bus2_transfer_ctrl.sv
// Bus2 line-transfer sequencer: arbitrates write-back vs fill requests, serialises
// lines into little-endian DATA2 beats and waits for the memory response.
module bus2_transfer_ctrl #(
    parameter int LINE_BYTES = 16,
    parameter int BUS_BYTES  = 2,
    parameter int ADDR_W     = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    wb_req,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [LINE_BYTES*8-1:0] wb_line,
    output logic                    wb_ack,
    input  logic                    fill_req,
    input  logic [ADDR_W-1:0]       fill_addr,
    output logic [LINE_BYTES*8-1:0] fill_line,
    output logic                    fill_done,
    output logic                    xfer_err,
    output logic                    busy,
    output logic [1:0]              c2_out,
    output logic                    c2_oe,
    output logic [ADDR_W-1:0]       a2_out,
    output logic [BUS_BYTES*8-1:0]  d2_out,
    output logic                    d2_oe,
    input  logic [1:0]              c2_in,
    input  logic [BUS_BYTES*8-1:0]  d2_in
);

    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BUS_W  = BUS_BYTES * 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C2_NOP   = 2'd0;
    localparam logic [1:0] C2_RESP  = 2'd1;
    localparam logic [1:0] C2_READ  = 2'd2;
    localparam logic [1:0] C2_WRITE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_BEAT = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_CMD  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_BEAT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rr_fill;
    logic                r_is_wb;
    logic                r_err;
    logic                r_mask_wb;
    logic                r_mask_fill;
    logic [LINE_W-1:0]   r_fill_line;
    logic [LINE_W-1:0]   r_rd_buf;

    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_rr_fill_nxt;
    logic                w_is_wb_nxt;
    logic                w_err_nxt;
    logic                w_mask_wb_nxt;
    logic                w_mask_fill_nxt;
    logic                w_capture;
    logic                w_commit;
    logic                w_wb_elig;
    logic                w_fill_elig;
    logic                w_last_beat;
    logic                w_timeout;
    logic [LINE_W-1:0]   w_rd_next;

    assign w_wb_elig   = wb_req & ~r_mask_wb;
    assign w_fill_elig = fill_req & ~r_mask_fill;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT));
    assign busy        = (r_state != S_IDLE);
    assign fill_line   = r_fill_line;

    always_comb begin
        w_rd_next = r_rd_buf;
        w_rd_next[int'(r_beat)*BUS_W +: BUS_W] = d2_in;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        w_cnt_nxt       = r_cnt;
        w_rr_fill_nxt   = r_rr_fill;
        w_is_wb_nxt     = r_is_wb;
        w_err_nxt       = r_err;
        w_mask_wb_nxt   = r_mask_wb;
        w_mask_fill_nxt = r_mask_fill;
        w_capture       = 1'b0;
        w_commit        = 1'b0;
        wb_ack          = 1'b0;
        fill_done       = 1'b0;
        xfer_err        = 1'b0;
        c2_out          = C2_NOP;
        c2_oe           = 1'b0;
        a2_out          = '0;
        d2_out          = '0;
        d2_oe           = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The mask only blocks the requester just served, and only for this one cycle.
                w_mask_wb_nxt   = 1'b0;
                w_mask_fill_nxt = 1'b0;
                w_beat_nxt      = '0;
                w_cnt_nxt       = '0;
                w_err_nxt       = 1'b0;
                if (w_wb_elig && (!w_fill_elig || !r_rr_fill)) begin
                    w_is_wb_nxt   = 1'b1;
                    w_rr_fill_nxt = 1'b1;
                    w_state_nxt   = S_WR_BEAT;
                end else if (w_fill_elig) begin
                    w_is_wb_nxt   = 1'b0;
                    w_rr_fill_nxt = 1'b0;
                    w_state_nxt   = S_RD_CMD;
                end
            end
            S_WR_BEAT: begin
                c2_out = C2_WRITE;
                c2_oe  = 1'b1;
                d2_oe  = 1'b1;
                a2_out = wb_addr;
                d2_out = wb_line[int'(r_beat)*BUS_W +: BUS_W];
                if (w_last_beat) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_WR_WAIT;
                end else begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            S_WR_WAIT: begin
                if (c2_in == C2_RESP) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_CMD: begin
                c2_out      = C2_READ;
                c2_oe       = 1'b1;
                a2_out      = fill_addr;
                w_beat_nxt  = '0;
                w_cnt_nxt   = CNT_W'(1);
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT, S_RD_BEAT: begin
                // Once the response arrives the remaining beats stream back-to-back.
                if (r_state == S_RD_BEAT || c2_in == C2_RESP) begin
                    w_capture = 1'b1;
                    if (w_last_beat) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_beat_nxt  = r_beat + BEAT_W'(1);
                        w_state_nxt = S_RD_BEAT;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                wb_ack          = r_is_wb;
                fill_done       = ~r_is_wb;
                xfer_err        = r_err;
                w_mask_wb_nxt   = r_is_wb;
                w_mask_fill_nxt = ~r_is_wb;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_cnt       <= '0;
            r_rr_fill   <= 1'b0;
            r_is_wb     <= 1'b0;
            r_err       <= 1'b0;
            r_mask_wb   <= 1'b0;
            r_mask_fill <= 1'b0;
            r_fill_line <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rr_fill   <= w_rr_fill_nxt;
            r_is_wb     <= w_is_wb_nxt;
            r_err       <= w_err_nxt;
            r_mask_wb   <= w_mask_wb_nxt;
            r_mask_fill <= w_mask_fill_nxt;
            if (w_commit) begin
                r_fill_line <= w_rd_next;
            end
        end
    end

    // Assembly buffer is pure data; it is only published to fill_line on the last beat.
    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_rd_buf <= w_rd_next;
        end
    end

endmodule
